// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline.
// Tracks in-flight RF writers (EX/MEM/WB slots), detects RAW hazards against
// the instruction in ID, generates stall/flush controls and counts stall cycles.
// Build option: define HAZARD_FWD_EN to enable operand forwarding; without it
// the ID instruction waits until every matching producer has left WB.
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rf_we_i,
  input  logic        id_is_load_i,
  input  logic        ex_redirect_i,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic [1:0]  fwd_a_sel_o,
  output logic [1:0]  fwd_b_sel_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;
  localparam logic [1:0] SelWb  = 2'b10;

  // Scoreboard slots
  logic       r_ex_valid, r_ex_we, r_ex_load;
  logic [4:0] r_ex_rd;
  logic       r_mem_valid, r_mem_we, r_mem_load;
  logic [4:0] r_mem_rd;
  logic       r_wb_valid, r_wb_we, r_wb_load;
  logic [4:0] r_wb_rd;

  logic [15:0] r_stall_cnt;

  // x0 is hard-wired zero, so it never creates a dependency
  function automatic logic slot_match(input logic       used,
                                      input logic [4:0] src,
                                      input logic       valid,
                                      input logic       we,
                                      input logic [4:0] rd);
    return used && valid && we && (rd != 5'd0) && (rd == src);
  endfunction

  logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
  logic w_ex_any, w_mem_any, w_wb_any;
  logic w_hazard, w_stall, w_redirect, w_issue, w_cnt_inc;

  assign w_ex_a  = slot_match(id_rs1_used_i, id_rs1_i, r_ex_valid,  r_ex_we,  r_ex_rd);
  assign w_ex_b  = slot_match(id_rs2_used_i, id_rs2_i, r_ex_valid,  r_ex_we,  r_ex_rd);
  assign w_mem_a = slot_match(id_rs1_used_i, id_rs1_i, r_mem_valid, r_mem_we, r_mem_rd);
  assign w_mem_b = slot_match(id_rs2_used_i, id_rs2_i, r_mem_valid, r_mem_we, r_mem_rd);
  assign w_wb_a  = slot_match(id_rs1_used_i, id_rs1_i, r_wb_valid,  r_wb_we,  r_wb_rd);
  assign w_wb_b  = slot_match(id_rs2_used_i, id_rs2_i, r_wb_valid,  r_wb_we,  r_wb_rd);

  assign w_ex_any  = w_ex_a  | w_ex_b;
  assign w_mem_any = w_mem_a | w_mem_b;
  assign w_wb_any  = w_wb_a  | w_wb_b;

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; the RF has no write-through,
  // so a producer sitting in WB also costs one cycle.
  assign w_hazard = id_valid_i & ((w_ex_any & r_ex_load) | w_wb_any);
`else
  assign w_hazard = id_valid_i & (w_ex_any | w_mem_any | w_wb_any);
`endif

  // All combinational controls are quiet while reset is held
  assign w_stall    = w_hazard & ~rst_i;
  assign w_redirect = ex_redirect_i & ~rst_i;
  assign w_issue    = id_valid_i & ~w_stall & ~w_redirect & ~rst_i;
  assign w_cnt_inc  = w_stall & ~w_redirect;

  // Redirect overrides stall: flush the wrong-path instruction instead of holding it
  always_comb begin
    pc_stall_o   = w_cnt_inc;
    ifid_stall_o = w_cnt_inc;
    ifid_flush_o = w_redirect;
    idex_flush_o = w_stall | w_redirect;
  end

  // Scoreboard shift: ID -> EX (bubble unless issuing) -> MEM -> WB
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_load  <= 1'b0;
      r_mem_rd    <= 5'd0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_load   <= 1'b0;
      r_wb_rd     <= 5'd0;
    end else begin
      r_ex_valid  <= w_issue;
      r_ex_we     <= id_rf_we_i;
      r_ex_load   <= id_is_load_i;
      r_ex_rd     <= id_rd_i;
      r_mem_valid <= r_ex_valid;
      r_mem_we    <= r_ex_we;
      r_mem_load  <= r_ex_load;
      r_mem_rd    <= r_ex_rd;
      r_wb_valid  <= r_mem_valid;
      r_wb_we     <= r_mem_we;
      r_wb_load   <= r_mem_load;
      r_wb_rd     <= r_mem_rd;
    end
  end

  // Load flags past EX only document the slot contents
`ifdef HAZARD_FWD_EN
  logic w_unused_load;
  assign w_unused_load = ^{r_mem_load, r_wb_load};
`else
  logic w_unused_load;
  assign w_unused_load = ^{r_ex_load, r_mem_load, r_wb_load, w_ex_any & w_mem_any};
`endif

`ifdef HAZARD_FWD_EN
  logic [1:0] w_fwd_a_d, w_fwd_b_d;
  logic [1:0] r_fwd_a, r_fwd_b;

  // Select is chosen in ID but consumed in EX: EX-slot producer will be in MEM,
  // MEM-slot producer will be in WB.
  always_comb begin
    w_fwd_a_d = SelRf;
    w_fwd_b_d = SelRf;
    if (w_issue) begin
      if (w_ex_a)       w_fwd_a_d = SelMem;
      else if (w_mem_a) w_fwd_a_d = SelWb;
      if (w_ex_b)       w_fwd_b_d = SelMem;
      else if (w_mem_b) w_fwd_b_d = SelWb;
    end
  end

  // Register forwarding selects alongside the ID/EX register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fwd_a <= SelRf;
      r_fwd_b <= SelRf;
    end else begin
      r_fwd_a <= w_fwd_a_d;
      r_fwd_b <= w_fwd_b_d;
    end
  end

  assign fwd_a_sel_o = r_fwd_a;
  assign fwd_b_sel_o = r_fwd_b;
`else
  logic [1:0] w_unused_sel;
  assign w_unused_sel = SelMem ^ SelWb;
  assign fwd_a_sel_o  = SelRf;
  assign fwd_b_sel_o  = SelRf;
`endif

  // Saturating stall-cycle counter; redirect cycles are not counted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= 16'd0;
    end else if (w_cnt_inc && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations track the HAZARD_FWD_EN build option.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic        id_rf_we_i, id_is_load_i, ex_redirect_i;
  logic        pc_stall_o, ifid_stall_o, ifid_flush_o, idex_flush_o;
  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;
  logic [15:0] stall_cnt_o;

  hazard_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rd_i       (id_rd_i),
    .id_rf_we_i    (id_rf_we_i),
    .id_is_load_i  (id_is_load_i),
    .ex_redirect_i (ex_redirect_i),
    .pc_stall_o    (pc_stall_o),
    .ifid_stall_o  (ifid_stall_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_flush_o  (idex_flush_o),
    .fwd_a_sel_o   (fwd_a_sel_o),
    .fwd_b_sel_o   (fwd_b_sel_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        pcs;
    logic        ifl;
    logic        idl;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive ID/control inputs, check combinational outputs mid-cycle,
  // then check registered outputs just after the edge.
  task automatic step(input string name, input logic v, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic we, input logic ld, input logic redir,
                      input logic rst, input logic pcs, input logic ifl, input logic idl,
                      input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    id_valid_i    = v;
    id_rd_i       = rd;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_rs1_used_i = u1;
    id_rs2_used_i = u2;
    id_rf_we_i    = we;
    id_is_load_i  = ld;
    ex_redirect_i = redir;
    rst_i         = rst;
    if (rst) exp_cnt = 16'd0;
    else if (pcs && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    e.pcs = pcs;
    e.ifl = ifl;
    e.idl = idl;
    e.a   = a;
    e.b   = b;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    @(negedge clk_i);
    e = exp_q.pop_front();
    check({name, ".pc_stall"},   {15'd0, pc_stall_o},   {15'd0, e.pcs});
    check({name, ".ifid_stall"}, {15'd0, ifid_stall_o}, {15'd0, e.pcs});
    check({name, ".ifid_flush"}, {15'd0, ifid_flush_o}, {15'd0, e.ifl});
    check({name, ".idex_flush"}, {15'd0, idex_flush_o}, {15'd0, e.idl});
    @(posedge clk_i);
    #1;
    check({name, ".fwd_a"},     {14'd0, fwd_a_sel_o}, {14'd0, e.a});
    check({name, ".fwd_b"},     {14'd0, fwd_b_sel_o}, {14'd0, e.b});
    check({name, ".stall_cnt"}, stall_cnt_o,          e.cnt);
  endtask

  task automatic rst_step(input string name);
    step(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
         1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic idle(input string name);
    step(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  // R-type ALU op: reads rs1/rs2, writes rd
  task automatic alu(input string name, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic pcs, input logic [1:0] a,
                     input logic [1:0] b);
    step(name, 1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
         pcs, 1'b0, pcs, a, b);
  endtask

  // Load: reads rs1 only
  task automatic load(input string name, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic pcs, input logic [1:0] a);
    step(name, 1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
         pcs, 1'b0, pcs, a, 2'b00);
  endtask

  initial begin
    rst_i = 1'b1; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; id_rf_we_i = 1'b0; id_is_load_i = 1'b0;
    ex_redirect_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset state; redirect and hazards are masked while reset is held
    rst_step("rst0");
    step("rst_redir", 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
         1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    rst_step("rst1");

    // x0 producer never creates a dependency
    alu("x0_prod", 5'd0, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
    alu("x0_use",  5'd1, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00);
    idle("x0_i0"); idle("x0_i1"); idle("x0_i2");

    // Back-to-back ALU dependency
    rst_step("rst_b2b");
    alu("add_x5", 5'd5, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
`ifdef HAZARD_FWD_EN
    alu("add_x6", 5'd6, 5'd5, 5'd1, 1'b0, 2'b01, 2'b00);
`else
    alu("sub_s1",  5'd9, 5'd5, 5'd2, 1'b1, 2'b00, 2'b00);
    alu("sub_s2",  5'd9, 5'd5, 5'd2, 1'b1, 2'b00, 2'b00);
    alu("sub_s3",  5'd9, 5'd5, 5'd2, 1'b1, 2'b00, 2'b00);
    alu("sub_iss", 5'd9, 5'd5, 5'd2, 1'b0, 2'b00, 2'b00);
`endif

    // Producer one slot ahead (MEM), dependency on rs2
    rst_step("rst_mem");
    alu("add_x5m", 5'd5, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
    idle("mem_gap");
`ifdef HAZARD_FWD_EN
    alu("mem_dep", 5'd9, 5'd2, 5'd5, 1'b0, 2'b00, 2'b10);
`else
    alu("mem_s1",  5'd9, 5'd2, 5'd5, 1'b1, 2'b00, 2'b00);
    alu("mem_s2",  5'd9, 5'd2, 5'd5, 1'b1, 2'b00, 2'b00);
    alu("mem_iss", 5'd9, 5'd2, 5'd5, 1'b0, 2'b00, 2'b00);
`endif

    // Producer in WB: one stall in both builds (no RF write-through)
    rst_step("rst_wb");
    alu("add_x5w", 5'd5, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
    idle("wb_gap0"); idle("wb_gap1");
    alu("wb_stall", 5'd9, 5'd5, 5'd5, 1'b1, 2'b00, 2'b00);
    alu("wb_iss",   5'd9, 5'd5, 5'd5, 1'b0, 2'b00, 2'b00);

    // Load-use
    rst_step("rst_lu");
    load("lw_x7", 5'd7, 5'd1, 1'b0, 2'b00);
`ifdef HAZARD_FWD_EN
    alu("lu_stall", 5'd8, 5'd7, 5'd7, 1'b1, 2'b00, 2'b00);
    alu("lu_iss",   5'd8, 5'd7, 5'd7, 1'b0, 2'b10, 2'b10);
`else
    alu("lu_s1",  5'd8, 5'd7, 5'd7, 1'b1, 2'b00, 2'b00);
    alu("lu_s2",  5'd8, 5'd7, 5'd7, 1'b1, 2'b00, 2'b00);
    alu("lu_s3",  5'd8, 5'd7, 5'd7, 1'b1, 2'b00, 2'b00);
    alu("lu_iss", 5'd8, 5'd7, 5'd7, 1'b0, 2'b00, 2'b00);
`endif

    // Redirect during a load-use stall: flush, no stall, count unchanged
    rst_step("rst_rd");
    load("lw_x7r", 5'd7, 5'd1, 1'b0, 2'b00);
    step("redir", 1'b1, 5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
         1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    alu("after_redir", 5'd3, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);

    // Reset in the middle of a stall discards the hazard
    rst_step("rst_mid0");
`ifdef HAZARD_FWD_EN
    load("lw_a", 5'd7, 5'd1, 1'b0, 2'b00);
    alu("lw_a_stall", 5'd8, 5'd7, 5'd7, 1'b1, 2'b00, 2'b00);
    alu("lw_a_iss",   5'd8, 5'd7, 5'd7, 1'b0, 2'b10, 2'b10);
    load("lw_b", 5'd10, 5'd1, 1'b0, 2'b00);
    step("rst_mid", 1'b1, 5'd11, 5'd10, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
         1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    alu("post_dep", 5'd11, 5'd10, 5'd10, 1'b0, 2'b00, 2'b00);
`else
    alu("add_x5r", 5'd5, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);
    alu("mid_s1",  5'd9, 5'd5, 5'd2, 1'b1, 2'b00, 2'b00);
    alu("mid_s2",  5'd9, 5'd5, 5'd2, 1'b1, 2'b00, 2'b00);
    step("rst_mid", 1'b1, 5'd9, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
         1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    alu("post_dep", 5'd9, 5'd5, 5'd2, 1'b0, 2'b00, 2'b00);
`endif
    alu("post_ind", 5'd3, 5'd1, 5'd2, 1'b0, 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
